// File: rtl/rst_sync_seq.sv
// Reset synchroniser with ordered, delayed release of several reset outputs.
// RST asserts every output at once, with or without a clock. Release is
// synchronous: a flop chain re-times the rising edge of RST, a hold period
// follows, and then the outputs are released one per step, bit 0 first.
// SW_RST_REQ pulls the outputs low again and re-runs the hold and step
// sequence. It does not touch the synchroniser.
module rst_sync_seq #(
    parameter int NUM_STAGES  = 2,
    parameter int NUM_DOMAINS = 3,
    parameter int HOLD_CYCLES = 4,
    parameter int STEP_DELAY  = 2
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   SW_RST_REQ,
    output logic [NUM_DOMAINS-1:0] SYNC_RST,
    output logic                   RST_DONE
);

    localparam int CNT_MAX  = (HOLD_CYCLES > STEP_DELAY) ? HOLD_CYCLES : STEP_DELAY;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int IDX_W    = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    // Index of the channel whose successor is the last one to be released.
    localparam int LAST_IDX = (NUM_DOMAINS >= 2) ? NUM_DOMAINS - 2 : 0;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    logic [NUM_STAGES-1:0]  sync_reg;
    logic                   sync_n;
    state_t                 state_reg;
    state_t                 state_next;
    logic [CNT_W-1:0]       cnt_reg;
    logic [CNT_W-1:0]       cnt_next;
    logic [IDX_W-1:0]       idx_reg;
    logic [IDX_W-1:0]       idx_next;
    logic [NUM_DOMAINS-1:0] sync_rst_reg;
    logic [NUM_DOMAINS-1:0] sync_rst_next;
    logic                   rst_done_reg;
    logic                   rst_done_next;

    // Synchroniser chain: cleared at once by RST, shifts in ones after RST rises.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[NUM_STAGES-2:0], 1'b1};
        end
    end

    assign sync_n = sync_reg[NUM_STAGES-1];

    // Sequencer state register, also cleared asynchronously by RST.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg    <= ST_HOLD;
            cnt_reg      <= '0;
            idx_reg      <= '0;
            sync_rst_reg <= '0;
            rst_done_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            idx_reg      <= idx_next;
            sync_rst_reg <= sync_rst_next;
            rst_done_reg <= rst_done_next;
        end
    end

    // Next-state logic: the firmware request overrides every state; otherwise
    // hold for HOLD_CYCLES qualified edges, then release one bit per STEP_DELAY.
    // The release shifts a one into the thermometer, so the outputs can only
    // fill from bit 0 upwards.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        idx_next      = idx_reg;
        sync_rst_next = sync_rst_reg;
        rst_done_next = rst_done_reg;

        if (SW_RST_REQ) begin
            state_next    = ST_HOLD;
            cnt_next      = '0;
            idx_next      = '0;
            sync_rst_next = '0;
            rst_done_next = 1'b0;
        end else begin
            case (state_reg)
                ST_HOLD: begin
                    if (sync_n) begin
                        if (cnt_reg == CNT_W'(HOLD_CYCLES - 1)) begin
                            sync_rst_next[0] = 1'b1;
                            idx_next         = '0;
                            cnt_next         = '0;
                            if (NUM_DOMAINS == 1) begin
                                state_next    = ST_DONE;
                                rst_done_next = 1'b1;
                            end else begin
                                state_next = ST_RELEASE;
                            end
                        end else begin
                            cnt_next = cnt_reg + CNT_W'(1);
                        end
                    end
                end
                ST_RELEASE: begin
                    if (cnt_reg == CNT_W'(STEP_DELAY - 1)) begin
                        sync_rst_next = (sync_rst_reg << 1) | NUM_DOMAINS'(1);
                        idx_next      = idx_reg + IDX_W'(1);
                        cnt_next      = '0;
                        if (idx_reg == IDX_W'(LAST_IDX)) begin
                            state_next    = ST_DONE;
                            rst_done_next = 1'b1;
                        end
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_next = ST_DONE;
                end
                default: begin
                    state_next    = ST_HOLD;
                    cnt_next      = '0;
                    idx_next      = '0;
                    sync_rst_next = '0;
                    rst_done_next = 1'b0;
                end
            endcase
        end
    end

    assign SYNC_RST = sync_rst_reg;
    assign RST_DONE = rst_done_reg;

endmodule

// File: tb/tb_rst_sync_seq.sv
// Testbench for rst_sync_seq.
// dut1 uses the default parameters. dut2 uses NUM_STAGES=3, NUM_DOMAINS=1 and
// HOLD_CYCLES=1.
// The bench has four parts:
//   - a table of vectors with expected outputs, one row per clock edge;
//   - hand-written sequences that pulse RST between clock edges;
//   - a randomized run;
//   - an edge-count reference model, checked on every cycle.
module tb_rst_sync_seq;

    logic       clk;
    logic       rst;
    logic       sw;
    logic [2:0] sync1;
    logic       done1;
    logic       rst2;
    logic       sw2;
    logic [0:0] sync2;
    logic       done2;

    int checks = 0;
    int errors = 0;

    // Reference model state. For each DUT it keeps two counts:
    //   m*_e = rising edges seen since RST last went high;
    //   m*_s = the edge at which SW_RST_REQ was last sampled high (0 if never).
    int m1_e = 0;
    int m1_s = 0;
    int m2_e = 0;
    int m2_s = 0;

    rst_sync_seq dut1 (
        .CLK        (clk),
        .RST        (rst),
        .SW_RST_REQ (sw),
        .SYNC_RST   (sync1),
        .RST_DONE   (done1)
    );

    rst_sync_seq #(
        .NUM_STAGES  (3),
        .NUM_DOMAINS (1),
        .HOLD_CYCLES (1),
        .STEP_DELAY  (2)
    ) dut2 (
        .CLK        (clk),
        .RST        (rst2),
        .SW_RST_REQ (sw2),
        .SYNC_RST   (sync2),
        .RST_DONE   (done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model edge and request bookkeeping for dut1.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m1_e <= 0;
            m1_s <= 0;
        end else begin
            m1_e <= m1_e + 1;
            if (sw) m1_s <= m1_e + 1;
        end
    end

    // Model edge and request bookkeeping for dut2.
    always @(posedge clk or negedge rst2) begin
        if (!rst2) begin
            m2_e <= 0;
            m2_s <= 0;
        end else begin
            m2_e <= m2_e + 1;
            if (sw2) m2_s <= m2_e + 1;
        end
    end

    // Number of channels released after edge e. Counting starts at the later
    // of two points: the synchroniser output going high, or the last request.
    // Bit k then rises at start + hold + k*step.
    function automatic int exp_count(input int e, input int s, input int ns,
                                     input int nd, input int hold, input int step);
        int start;
        int n;
        start = (s > ns) ? s : ns;
        if (e < start + hold) return 0;
        n = 1 + (e - start - hold) / step;
        return (n > nd) ? nd : n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive the requests, let one rising edge pass, then compare both DUTs
    // with the model on the falling edge.
    task automatic tick(input logic sw_v, input logic sw2_v);
        int         n1;
        int         n2;
        logic [2:0] th;
        sw  = sw_v;
        sw2 = sw2_v;
        @(posedge clk);
        @(negedge clk);
        n1 = exp_count(m1_e, m1_s, 2, 3, 4, 2);
        n2 = exp_count(m2_e, m2_s, 3, 1, 1, 2);
        check("model_sync1", {29'd0, sync1}, (32'd1 << n1) - 32'd1);
        check("model_done1", {31'd0, done1}, {31'd0, n1 == 3});
        check("model_sync2", {31'd0, sync2}, (32'd1 << n2) - 32'd1);
        check("model_done2", {31'd0, done2}, {31'd0, n2 == 1});
        th = sync1 & (sync1 + 3'd1);
        check("thermo1", {29'd0, th}, 32'd0);
    endtask

    // Pulse a reset low for 3 ns between two clock edges. While it is low,
    // the outputs must already be cleared, before any clock edge arrives.
    task automatic glitch(input logic g1, input logic g2);
        #1;
        if (g1) rst = 1'b0;
        if (g2) rst2 = 1'b0;
        #1;
        if (g1) begin
            check("async_sync1", {29'd0, sync1}, 32'd0);
            check("async_done1", {31'd0, done1}, 32'd0);
        end
        if (g2) begin
            check("async_sync2", {31'd0, sync2}, 32'd0);
            check("async_done2", {31'd0, done2}, 32'd0);
        end
        #2;
        rst  = 1'b1;
        rst2 = 1'b1;
    endtask

    typedef struct {
        logic       sw;
        logic [2:0] sync;
        logic       done;
        logic       d2;
    } vec_t;

    vec_t vecs[35];

    initial begin
        // Rows 0-11: power-on release (outputs 001 at edge 6, 011 at 8, 111 at 10).
        vecs[0]  = '{1'b0, 3'b000, 1'b0, 1'b0}; vecs[1]  = '{1'b0, 3'b000, 1'b0, 1'b0}; vecs[2]  = '{1'b0, 3'b000, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 3'b000, 1'b0, 1'b1}; vecs[4]  = '{1'b0, 3'b000, 1'b0, 1'b1}; vecs[5]  = '{1'b0, 3'b001, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 3'b001, 1'b0, 1'b1}; vecs[7]  = '{1'b0, 3'b011, 1'b0, 1'b1}; vecs[8]  = '{1'b0, 3'b011, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 3'b111, 1'b1, 1'b1}; vecs[10] = '{1'b0, 3'b111, 1'b1, 1'b1}; vecs[11] = '{1'b0, 3'b111, 1'b1, 1'b1};
        // Rows 12-20: one-cycle request at E (outputs 001 at E+4, 011 at E+6, 111 at E+8).
        vecs[12] = '{1'b1, 3'b000, 1'b0, 1'b1}; vecs[13] = '{1'b0, 3'b000, 1'b0, 1'b1}; vecs[14] = '{1'b0, 3'b000, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 3'b000, 1'b0, 1'b1}; vecs[16] = '{1'b0, 3'b001, 1'b0, 1'b1}; vecs[17] = '{1'b0, 3'b001, 1'b0, 1'b1};
        vecs[18] = '{1'b0, 3'b011, 1'b0, 1'b1}; vecs[19] = '{1'b0, 3'b011, 1'b0, 1'b1}; vecs[20] = '{1'b0, 3'b111, 1'b1, 1'b1};
        // Rows 21-34: request held for E..E+5 (outputs 001 at E+9, 011 at E+11, 111 at E+13).
        vecs[21] = '{1'b1, 3'b000, 1'b0, 1'b1}; vecs[22] = '{1'b1, 3'b000, 1'b0, 1'b1}; vecs[23] = '{1'b1, 3'b000, 1'b0, 1'b1};
        vecs[24] = '{1'b1, 3'b000, 1'b0, 1'b1}; vecs[25] = '{1'b1, 3'b000, 1'b0, 1'b1}; vecs[26] = '{1'b1, 3'b000, 1'b0, 1'b1};
        vecs[27] = '{1'b0, 3'b000, 1'b0, 1'b1}; vecs[28] = '{1'b0, 3'b000, 1'b0, 1'b1}; vecs[29] = '{1'b0, 3'b000, 1'b0, 1'b1};
        vecs[30] = '{1'b0, 3'b001, 1'b0, 1'b1}; vecs[31] = '{1'b0, 3'b001, 1'b0, 1'b1}; vecs[32] = '{1'b0, 3'b011, 1'b0, 1'b1};
        vecs[33] = '{1'b0, 3'b011, 1'b0, 1'b1}; vecs[34] = '{1'b0, 3'b111, 1'b1, 1'b1};

        rst  = 1'b1;
        rst2 = 1'b1;
        sw   = 1'b0;
        sw2  = 1'b0;
        #1;
        rst  = 1'b0;
        rst2 = 1'b0;

        // Reset state, with clock edges passing while RST is held low.
        repeat (2) @(negedge clk);
        #1;
        check("reset_sync1", {29'd0, sync1}, 32'd0);
        check("reset_done1", {31'd0, done1}, 32'd0);
        check("reset_sync2", {31'd0, sync2}, 32'd0);
        check("reset_done2", {31'd0, done2}, 32'd0);

        // Release both resets in the middle of a clock cycle.
        #1;
        rst  = 1'b1;
        rst2 = 1'b1;

        for (int i = 0; i < 35; i++) begin
            tick(vecs[i].sw, 1'b0);
            check("vec_sync1", {29'd0, sync1}, {29'd0, vecs[i].sync});
            check("vec_done1", {31'd0, done1}, {31'd0, vecs[i].done});
            check("vec_sync2", {31'd0, sync2}, {31'd0, vecs[i].d2});
            check("vec_done2", {31'd0, done2}, {31'd0, vecs[i].d2});
            $display("vec %0d sw=%0b sync1=%b done1=%b sync2=%b done2=%b",
                     i, vecs[i].sw, sync1, done1, sync2, done2);
        end

        // A 0.3-period RST glitch while in DONE restarts the whole sequence;
        // the first release comes 6 edges later.
        glitch(1'b1, 1'b0);
        for (int e = 1; e <= 7; e++) begin
            tick(1'b0, 1'b0);
            check("glitch_restart", {29'd0, sync1}, (e >= 6) ? 32'd1 : 32'd0);
        end

        // RST pulse between edges 7 and 8 of a sequence, then the full restart.
        glitch(1'b1, 1'b0);
        for (int e = 1; e <= 10; e++) begin
            tick(1'b0, 1'b0);
            check("mid_seq_sync", {29'd0, sync1},
                  (e >= 10) ? 32'd7 : (e >= 8) ? 32'd3 : (e >= 6) ? 32'd1 : 32'd0);
            check("mid_seq_done", {31'd0, done1}, (e >= 10) ? 32'd1 : 32'd0);
        end

        // Randomized requests and occasional RST glitches, checked by the model.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 39) == 0) glitch(1'b1, $urandom_range(0, 1) == 1);
            tick($urandom_range(0, 11) == 0, $urandom_range(0, 7) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
